push_arbiter: RTL and testbench

PUSH_ARBITER -- requirements
Module: push_arbiter

---
 rtl/push_arbiter.sv | 96 +++++++++
 tb/tb_push_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/push_arbiter.sv
// push_arbiter: reaction-game round arbiter with a random dark delay, jump detection and restart control.
module push_arbiter #(
    parameter int         MIN_DLY   = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic pbl,
    input  logic pbr,
    input  logic endrnd,
    input  logic new_game,
    output logic leds_on,
    output logic winrnd,
    output logic right,
    output logic tie,
    output logic clear_score
);
    typedef enum logic [2:0] {DARK, LIT, RESULT, HOLD, OVER} state_t;
    localparam logic [8:0] MIN9 = 9'(MIN_DLY);
    state_t state, state_d;
    logic [8:0] cnt, cnt_d;
    logic [7:0] lfsr;
    logic pbl_q, pbr_q, ev_l, ev_r, ev;
    logic leds_d, win_d, right_d, tie_d, clr_d;
    // previous-button registers reset to 1 so a button held through reset is not an event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= DARK;
            cnt         <= MIN9;
            lfsr        <= LFSR_SEED;
            pbl_q       <= 1'b1;
            pbr_q       <= 1'b1;
            leds_on     <= 1'b0;
            winrnd      <= 1'b0;
            right       <= 1'b0;
            tie         <= 1'b0;
            clear_score <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            lfsr        <= {lfsr[6:0], ^(lfsr & 8'hB8)};
            pbl_q       <= pbl;
            pbr_q       <= pbr;
            leds_on     <= leds_d;
            winrnd      <= win_d;
            right       <= right_d;
            tie         <= tie_d;
            clear_score <= clr_d;
        end
    end
    always_comb begin
        ev_l    = pbl & ~pbl_q;
        ev_r    = pbr & ~pbr_q;
        ev      = ev_l | ev_r;
        state_d = state;
        cnt_d   = cnt;
        leds_d  = 1'b0;
        win_d   = 1'b0;
        right_d = right;
        tie_d   = tie;
        clr_d   = 1'b0;
        if (new_game) begin
            state_d = HOLD;
            clr_d   = 1'b1;
        end else begin
            case (state)
                DARK, LIT: begin
                    if (ev) begin
                        state_d = RESULT;
                        win_d   = 1'b1;
                        right_d = ev_r & ~ev_l;
                        tie_d   = ev_l & ev_r;
                        leds_d  = (state == LIT);
                    end else if (state == LIT) begin
                        leds_d = 1'b1;
                    end else if (cnt == 9'd1) begin
                        state_d = LIT;
                        leds_d  = 1'b1;
                    end else begin
                        cnt_d = cnt - 9'd1;
                    end
                end
                RESULT: state_d = HOLD;
                HOLD: begin
                    if (endrnd) begin
                        state_d = OVER;
                    end else if (!pbl && !pbr) begin
                        state_d = DARK;
                        cnt_d   = MIN9 + {1'b0, lfsr};
                    end
                end
                default: state_d = state;
            endcase
        end
    end
endmodule

// File: tb/tb_push_arbiter.sv
// tb_push_arbiter: directed and random stimulus against a timestamp-based reference of the game rules.
module tb_push_arbiter;
    localparam int         MIN  = 16;
    localparam logic [7:0] SEED = 8'hA5;
    logic clk = 1'b0;
    logic rst, pbl, pbr, endrnd, new_game;
    logic leds_on, winrnd, right, tie, clear_score;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    push_arbiter #(.MIN_DLY(MIN), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .endrnd(endrnd), .new_game(new_game),
        .leds_on(leds_on), .winrnd(winrnd), .right(right), .tie(tie), .clear_score(clear_score)
    );
    typedef enum {M_DARK, M_RES, M_HOLD, M_OVER} mph_t;
    mph_t ph;
    int cyc, lit_at;
    bit m_pl, m_pr, e_led, e_win, e_right, e_tie, e_clr;
    logic [7:0] seq [8192];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    // lfsr value k cycles after reset release
    task automatic build_seq();
        seq[0] = SEED;
        for (int i = 1; i < 8192; i++) seq[i] = {seq[i-1][6:0], ^(seq[i-1] & 8'hB8)};
    endtask
    task automatic model_reset();
        ph = M_DARK; cyc = 0; lit_at = MIN;
        m_pl = 1; m_pr = 1;
        e_led = 0; e_win = 0; e_right = 0; e_tie = 0; e_clr = 0;
    endtask
    task automatic model_step(input bit l, input bit r, input bit e, input bit ng);
        bit el, er, lit_now;
        el = l && !m_pl;
        er = r && !m_pr;
        lit_now = (ph == M_DARK) && (cyc >= lit_at);
        e_win = 0; e_clr = 0; e_led = 0;
        if (ng) begin
            ph = M_HOLD; e_clr = 1;
        end else begin
            case (ph)
                M_DARK: if (el || er) begin
                    ph = M_RES; e_win = 1; e_right = er && !el; e_tie = el && er; e_led = lit_now;
                end else e_led = (cyc + 1 >= lit_at);
                M_RES: ph = M_HOLD;
                M_HOLD: if (e) ph = M_OVER;
                    else if (!l && !r) begin
                        ph = M_DARK; lit_at = cyc + 1 + MIN + int'(seq[cyc]);
                    end
                default: ;
            endcase
        end
        m_pl = l; m_pr = r; cyc++;
    endtask
    task automatic compare();
        check("leds_on", leds_on, e_led);
        check("winrnd", winrnd, e_win);
        check("right", right, e_right);
        check("tie", tie, e_tie);
        check("clear_score", clear_score, e_clr);
    endtask
    task automatic tick(input bit l, input bit r, input bit e, input bit ng);
        pbl = l; pbr = r; endrnd = e; new_game = ng;
        model_step(l, r, e, ng);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask
    task automatic wait_lit();
        int n = 0;
        while (!leds_on && n < 400) begin
            tick(0, 0, 0, 0);
            n++;
        end
        check("lit_wait", leds_on, 1);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bit l, r;
        build_seq();
        rst = 1; pbl = 0; pbr = 0; endrnd = 0; new_game = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare();
        rst = 0;
        repeat (15) tick(0, 0, 0, 0);
        check("dark_after_15", leds_on, 0);
        tick(0, 0, 0, 0);
        check("lit_after_16", leds_on, 1);
        tick(0, 1, 0, 0);
        check("lit_push_right", right, 1);
        tick(0, 1, 0, 0);
        for (int i = 0; i < 9; i++) tick(i == 4, 1, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("jump_leds", leds_on, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        tick(1, 1, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 1, 0);
        tick(0, 0, 0, 1);
        check("clear_pulse", clear_score, 1);
        tick(0, 0, 0, 0);
        check("clear_once", clear_score, 0);
        wait_lit();
        tick(1, 1, 0, 0);
        check("tie_flag", tie, 1);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 1);
        tick(0, 0, 0, 0);
        wait_lit();
        tick(0, 1, 0, 0);
        rst = 1; pbl = 1;
        #1;
        check("rst_async_win", winrnd, 0);
        check("rst_async_leds", leds_on, 0);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        compare();
        rst = 0;
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        tick(0, 0, 0, 0);
        l = 0; r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) l = !l;
            if ($urandom_range(0, 7) == 0) r = !r;
            tick(l, r, $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
